div_unit: RTL

Iterative RV32M divide unit in the EXEC stage. It computes DIV/DIVU/REM/REMU over 32 restoring-division cycles. While working it raises a stall request to the hazard unit, and it obeys that unit's flush and hold outputs, so it acts as the requesting end of the stall/flush interface. The result is presented for the cycle in which EXEC advances.

---
 rtl/div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit (restoring, one bit/cycle)
//            acting as the stall-requesting end of the hazard interface.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            sel_rem_q, sel_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  logic            is_signed, a_neg, b_neg, div_zero, overflow, no_borrow;
  logic [XLEN-1:0] a_mag, b_mag, step_rem, step_quo, quo_fix, rem_fix;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[XLEN-1];
    b_neg     = is_signed & b[XLEN-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    div_zero  = (b == '0);
    overflow  = is_signed & (a == MIN_INT) & (b == '1);

    // On borrow the shifted value is already below the divisor, so it fits XLEN bits.
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    no_borrow = ~diff[XLEN];
    step_rem  = no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    step_quo  = {quo_q[XLEN-2:0], no_borrow};
    quo_fix   = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    rem_fix   = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (div_zero) begin
            result_d = op[1] ? a : '1;
            state_d  = S_DONE;
          end else if (overflow) begin
            result_d = op[1] ? '0 : MIN_INT;
            state_d  = S_DONE;
          end else begin
            sel_rem_d = op[1];
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            count_d   = '0;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            result_d = sel_rem_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || !hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy   = ~flush & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
  assign done   = (state_q == S_DONE) & ~flush;
  assign result = result_q;

endmodule
`default_nettype wire
